// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte FIFO fed by new_data strobes, frame FSM serialising onto tx.
// Optional macro UART_TX_OVF_CNT_EN adds ovf_count, a saturating count of dropped pushes.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        new_data,
  input  logic [31:0]                 DATA_R,
  input  logic [31:0]                 CONFIG_R,
  input  logic [31:0]                 BAUD_DIV,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_done,
  output logic                        overflow
`ifdef UART_TX_OVF_CNT_EN
  ,
  output logic [7:0]                  ovf_count
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNTF_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTF_W-1:0]  count_q;
  logic [7:0]         byte_q;
  logic               par_en_q, par_odd_q, two_stop_q;
  logic [CNT_W-1:0]   div_q, div_new, cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic               stop2_q, stop2_d;
  logic               tx_q, tx_d, done_q, done_d, ovf_q;
  logic               tx_en, start_frame, push_ok, push_drop, bit_end;
  logic               unused_bits;

  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

  assign unused_bits = ^{DATA_R[31:8], CONFIG_R[31:4], BAUD_DIV};

  assign tx_en       = CONFIG_R[0];
  assign div_new     = (BAUD_DIV[CNT_W-1:0] == '0) ? CNT_W'(1) : BAUD_DIV[CNT_W-1:0];
  assign bit_end     = (cnt_q == '0);
  assign start_frame = (state_q == IDLE) && tx_en && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_ok     = new_data && ((count_q != CNTF_W'(FIFO_DEPTH)) || start_frame);
  assign push_drop   = new_data && !push_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_frame) begin
          state_d = START;
          cnt_d   = div_new - CNT_W'(1);
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          cnt_d   = div_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_q - CNT_W'(1);
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
            stop2_d = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop2_d = 1'b0;
          cnt_d   = div_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
            cnt_d   = div_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_q[bit_d];
      PARITY:  tx_d = parity_bit(byte_q, par_odd_q);
      default: tx_d = 1'b1;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ovf_q   <= push_drop;
      if (push_ok)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (start_frame) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, start_frame})
        2'b10:   count_q <= count_q + CNTF_W'(1);
        2'b01:   count_q <= count_q - CNTF_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---- data registers: FIFO storage and per-frame snapshot ----
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= DATA_R[7:0];
    if (start_frame) begin
      byte_q     <= mem[rd_ptr_q];
      par_en_q   <= CONFIG_R[1];
      par_odd_q  <= CONFIG_R[2];
      two_stop_q <= CONFIG_R[3];
      div_q      <= div_new;
    end
  end

`ifdef UART_TX_OVF_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)                     ovf_cnt_q <= '0;
    else if (push_ok && CONFIG_R[5]) ovf_cnt_q <= '0;
    else if (push_drop)             ovf_cnt_q <= sat_inc8(ovf_cnt_q);
  end

  assign ovf_count = ovf_cnt_q;
`endif

  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_full  = (count_q == CNTF_W'(FIFO_DEPTH));
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed scenarios plus randomized frames
// compared against a per-cycle expected tx waveform built from the frame rules.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_data = 1'b0;
  logic [31:0] DATA_R = '0, CONFIG_R = '0, BAUD_DIV = '0;
  logic        tx, busy, fifo_full, tx_done, overflow;
  logic [2:0]  fifo_count;
`ifdef UART_TX_OVF_CNT_EN
  logic [7:0]  ovf_count;
  int          exp_ovf = 0;
`endif

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_data   (new_data),
    .DATA_R     (DATA_R),
    .CONFIG_R   (CONFIG_R),
    .BAUD_DIV   (BAUD_DIV),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .tx_done    (tx_done),
    .overflow   (overflow)
`ifdef UART_TX_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for every cycle of one frame, starting at the start bit.
  function automatic void model_frame(input logic [7:0] b, input logic [31:0] cfg,
                                      input logic [31:0] div_reg);
    int d;
    int ones;
    d = (div_reg[15:0] == 16'd0) ? 1 : int'(div_reg[15:0]);
    ones = $countones(b);
    exp_q.delete();
    repeat (d) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (d) exp_q.push_back(b[i]);
    if (cfg[1]) repeat (d) exp_q.push_back(cfg[2] ? ((ones % 2) == 0) : ((ones % 2) == 1));
    repeat ((cfg[3] ? 2 : 1) * d) exp_q.push_back(1'b1);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests++;
    if ({tx, busy, fifo_full, fifo_count, tx_done, overflow} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got tx=%b busy=%b full=%b cnt=%0d done=%b ovf=%b, want 1 0 0 0 0 0",
               tx, busy, fifo_full, fifo_count, tx_done, overflow);
    end
`ifdef UART_TX_OVF_CNT_EN
    tests++;
    if (ovf_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_ovf_count: got %0d want 0", ovf_count);
    end
`endif
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    CONFIG_R = 32'h1;
    BAUD_DIV = 32'd4;
    DATA_R   = 32'h55;
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    tests++;
    if (tx !== 1'b1 || fifo_count !== 3'd1) begin
      fails++;
      $display("FAIL single_push: got tx=%b cnt=%0d want tx=1 cnt=1", tx, fifo_count);
    end
    model_frame(8'h55, CONFIG_R, BAUD_DIV);
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (tx !== exp_q[i] || tx_done !== 1'b0) begin
        fails++;
        $display("FAIL single_tx cyc%0d: got tx=%b done=%b want tx=%b done=0", i, tx, tx_done, exp_q[i]);
      end
      tick();
    end
    tests++;
    if (tx_done !== 1'b1 || tx !== 1'b1) begin
      fails++;
      $display("FAIL single_done: got done=%b tx=%b want 1 1", tx_done, tx);
    end
    tick();
    tests++;
    if (tx_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_after: got done=%b busy=%b want 0 0", tx_done, busy);
    end
  endtask

  task automatic test_parity_two_stop();
    CONFIG_R = 32'hF;
    BAUD_DIV = 32'd2;
    DATA_R   = 32'h03;
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    model_frame(8'h03, CONFIG_R, BAUD_DIV);
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (tx !== exp_q[i]) begin
        fails++;
        $display("FAIL parity_tx cyc%0d: got %b want %b", i, tx, exp_q[i]);
      end
      tick();
    end
    tests++;
    if (tx_done !== 1'b1) begin
      fails++;
      $display("FAIL parity_done: got %b want 1", tx_done);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[$];
    CONFIG_R = 32'h0;
    BAUD_DIV = 32'd3;
    for (int k = 0; k < 5; k++) begin
      DATA_R   = 32'h10 + k;
      new_data = 1'b1;
      tick();
      if (k < 4) begin
        bytes.push_back(8'h10 + 8'(k));
        tests++;
        if (overflow !== 1'b0 || fifo_count !== 3'(k + 1) || fifo_full !== (k == 3)) begin
          fails++;
          $display("FAIL ovf_fill%0d: got ovf=%b cnt=%0d full=%b want 0 %0d %b",
                   k, overflow, fifo_count, fifo_full, k + 1, k == 3);
        end
      end
    end
    new_data = 1'b0;
    tests++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      fails++;
      $display("FAIL ovf_drop: got ovf=%b cnt=%0d want 1 4", overflow, fifo_count);
    end
`ifdef UART_TX_OVF_CNT_EN
    exp_ovf++;
`endif
    tick();
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pulse_len: got %b want 0", overflow);
    end
`ifdef UART_TX_OVF_CNT_EN
    tests++;
    if (ovf_count !== 8'(exp_ovf)) begin
      fails++;
      $display("FAIL ovf_count: got %0d want %0d", ovf_count, exp_ovf);
    end
`endif
    CONFIG_R = 32'h1;
    tick();
    for (int f = 0; f < 4; f++) begin
      model_frame(bytes[f], CONFIG_R, BAUD_DIV);
      if (f > 0) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (tx !== exp_q[i]) begin
          fails++;
          $display("FAIL ovf_tx f%0d cyc%0d: got %b want %b", f, i, tx, exp_q[i]);
        end
        tick();
      end
      tests++;
      if (tx_done !== 1'b1) begin
        fails++;
        $display("FAIL ovf_done f%0d: got %b want 1", f, tx_done);
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ovf_drained: busy got %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_push_pop_full();
    logic [7:0] bytes[$];
    logic [7:0] b;
    CONFIG_R = 32'h0;
    BAUD_DIV = 32'd1;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      bytes.push_back(b);
      DATA_R   = {24'd0, b};
      new_data = 1'b1;
      tick();
    end
    tests++;
    if (fifo_full !== 1'b1) begin
      fails++;
      $display("FAIL pp_full: got %b want 1", fifo_full);
    end
    b = 8'($urandom);
    bytes.push_back(b);
    DATA_R   = {24'd0, b};
    CONFIG_R = 32'h1;
    tick();
    new_data = 1'b0;
    tests++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL pp_same_cycle: got cnt=%0d ovf=%b want 4 0", fifo_count, overflow);
    end
    for (int f = 0; f < 5; f++) begin
      model_frame(bytes[f], CONFIG_R, BAUD_DIV);
      if (f > 0) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (tx !== exp_q[i]) begin
          fails++;
          $display("FAIL pp_tx f%0d cyc%0d: got %b want %b", f, i, tx, exp_q[i]);
        end
        tick();
      end
      tests++;
      if (tx_done !== 1'b1) begin
        fails++;
        $display("FAIL pp_done f%0d: got %b want 1", f, tx_done);
      end
    end
    tick();
  endtask

  task automatic test_div0_midframe();
    logic [7:0] b;
    // Divisor 0 behaves as 1: ten-cycle 8N1 frame.
    CONFIG_R = 32'h1;
    BAUD_DIV = 32'd0;
    b = 8'($urandom);
    DATA_R   = {24'd0, b};
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    model_frame(b, CONFIG_R, BAUD_DIV);
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (tx !== exp_q[i]) begin
        fails++;
        $display("FAIL div0_tx cyc%0d: got %b want %b", i, tx, exp_q[i]);
      end
      tick();
    end
    tests++;
    if (tx_done !== 1'b1) begin
      fails++;
      $display("FAIL div0_done: got %b want 1", tx_done);
    end
    tick();
    // Register writes during DATA must not disturb the frame in flight.
    CONFIG_R = 32'h3;
    BAUD_DIV = 32'd3;
    b = 8'($urandom);
    DATA_R   = {24'd0, b};
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    model_frame(b, CONFIG_R, BAUD_DIV);
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 15) begin
        BAUD_DIV = 32'd7;
        CONFIG_R = 32'h0C;
      end
      tests++;
      if (tx !== exp_q[i]) begin
        fails++;
        $display("FAIL mid_tx cyc%0d: got %b want %b", i, tx, exp_q[i]);
      end
      tick();
    end
    tests++;
    if (tx_done !== 1'b1) begin
      fails++;
      $display("FAIL mid_done: got %b want 1", tx_done);
    end
    tick();
    CONFIG_R = 32'h0;
  endtask

  task automatic test_random_frames();
    logic [7:0]  bytes[$];
    logic [31:0] cfg;
    logic [31:0] div;
    int          n;
    for (int it = 0; it < 6; it++) begin
      bytes.delete();
      n   = $urandom_range(1, 3);
      cfg = 32'($urandom) & 32'hE;
      div = 32'($urandom_range(0, 4));
      CONFIG_R = cfg;
      BAUD_DIV = div;
      for (int k = 0; k < n; k++) begin
        bytes.push_back(8'($urandom));
        DATA_R   = {24'd0, bytes[k]};
        new_data = 1'b1;
        tick();
      end
      new_data = 1'b0;
      tests++;
      if (fifo_count !== 3'(n) || busy !== 1'b1) begin
        fails++;
        $display("FAIL rand_queue it%0d: got cnt=%0d busy=%b want %0d 1", it, fifo_count, busy, n);
      end
      CONFIG_R = cfg | 32'h1;
      tick();
      for (int f = 0; f < n; f++) begin
        model_frame(bytes[f], CONFIG_R, BAUD_DIV);
        if (f > 0) tick();
        for (int i = 0; i < exp_q.size(); i++) begin
          tests++;
          if (tx !== exp_q[i]) begin
            fails++;
            $display("FAIL rand_tx it%0d f%0d cyc%0d cfg=%h div=%0d: got %b want %b",
                     it, f, i, cfg, div, tx, exp_q[i]);
          end
          tick();
        end
        tests++;
        if (tx_done !== 1'b1) begin
          fails++;
          $display("FAIL rand_done it%0d f%0d: got %b want 1", it, f, tx_done);
        end
      end
      tick();
      tests++;
      if (tx_done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rand_idle it%0d: got done=%b busy=%b want 0 0", it, tx_done, busy);
      end
      CONFIG_R = 32'h0;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int         bad;
    b = 8'($urandom);
    CONFIG_R = 32'h0;
    BAUD_DIV = 32'd2;
    DATA_R   = {24'd0, b};
    new_data = 1'b1;
    tick();
    DATA_R   = 32'($urandom) & 32'hFF;
    tick();
    new_data = 1'b0;
    CONFIG_R = 32'h1;
    tick();
    repeat (8) tick();
    tests++;
    if (tx !== b[3]) begin
      fails++;
      $display("FAIL rst_bit3: got %b want %b", tx, b[3]);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || tx_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got tx=%b cnt=%0d done=%b busy=%b want 1 0 0 0",
               tx, fifo_count, tx_done, busy);
    end
`ifdef UART_TX_OVF_CNT_EN
    tests++;
    if (ovf_count !== 8'd0) begin
      fails++;
      $display("FAIL rst_ovf_count: got %0d want 0", ovf_count);
    end
`endif
    reset = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (tx !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_parity_two_stop();
    test_overflow();
    test_push_pop_full();
    test_div0_midframe();
    test_random_frames();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit controller for the memory-mapped UART registers exported by the single-cycle/pipelined datapath (DATA_R, CONFIG_R, BAUD_DIV, new_data).
- Each new_data strobe pushes DATA_R[7:0] into a small FIFO.
- A frame FSM serialises queued bytes onto tx using the frame format in CONFIG_R and the bit period in BAUD_DIV.
- Sits beside datapath at top level and drives the board TX pin.

Parameters:
FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16
CNT_W, 16, baud counter width; uses BAUD_DIV[CNT_W-1:0]

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
new_data  input  1  one-cycle strobe: store to UART data address completed
DATA_R  input  32  data register; byte = [7:0]
CONFIG_R  input  32  [0] tx_en, [1] parity_en, [2] parity_odd, [3] two_stop; other bits ignored
BAUD_DIV  input  32  clock cycles per bit; [CNT_W-1:0] used
tx  output  1  serial line, idle high
busy  output  1  high when state != IDLE or FIFO non-empty
fifo_full  output  1  count == FIFO_DEPTH
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries queued
tx_done  output  1  one-cycle pulse at end of each frame
overflow  output  1  one-cycle pulse when a push is dropped

Behaviour:
Reset:
- Applies at a clk edge while reset==0.
- Values after reset: tx=1, busy=0, fifo_full=0, fifo_count=0, tx_done=0, overflow=0, state=IDLE, FIFO pointers 0.
- Reset mid-frame aborts the frame immediately; tx returns to 1 on the same edge.

FIFO:
- Push on new_data.
- Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
- Otherwise the byte is dropped, overflow=1 for one cycle, and FIFO contents are unchanged.
- Pop happens only on the IDLE->START transition.
- Simultaneous push and pop: count is unchanged; the pushed byte goes to the tail.
- Pointers wrap modulo FIFO_DEPTH.

Frame latching:
- At frame start (IDLE->START) latch: byte, parity_en, parity_odd, two_stop, and div = (BAUD_DIV[CNT_W-1:0]==0) ? 1 : BAUD_DIV[CNT_W-1:0].
- Register changes mid-frame do not affect the current frame.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. Moves to START when tx_en==1 and count>0.
- START: tx=0 for div cycles.
- DATA: 8 bits, LSB first, each held for div cycles. Bit index 0..7.
- PARITY: entered only if parity_en.
  - Even parity: tx = XOR of the byte.
  - Odd parity: tx = inverted XOR of the byte.
- STOP: tx=1 for div cycles, or 2*div cycles if two_stop.
- Leaving STOP: tx_done=1 for that one cycle, then return to IDLE.

Timing:
- Bit timing uses a down-counter loaded with div-1 on each bit entry; the bit advances when the counter reaches 0.
- Frame length = (1+8+parity_en+1+two_stop)*div cycles.
- IDLE lasts at least 1 cycle between frames, so the minimum inter-frame gap is one tx=1 cycle.
- Latency: a new_data into an empty FIFO with tx_en=1 and IDLE gives tx=0 (start bit) 2 cycles after the strobe edge: push, then IDLE->START.
- tx_en falling mid-frame: the current frame completes; FIFO is held; no new frame starts.
- All outputs are registered except busy, fifo_full and fifo_count, which are decoded from registered state.

Optional Feature:
Macro UART_TX_OVF_CNT_EN.
- Defined:
  - Adds output ovf_count [7:0] counting dropped pushes.
  - Saturates at 255; reset value 0.
  - Clears when a new_data push is accepted while CONFIG_R[5]==1 (clear has priority over increment in the same cycle).
- Undefined: no ovf_count port and no counter logic; CONFIG_R[5] is ignored; the overflow pulse is still present.

Test Plan:
1. Single frame, 8N1:
   - Stimulus: reset low 2 cycles; CONFIG_R=0x1, BAUD_DIV=4; new_data with DATA_R=0x55.
   - Required: tx=0 at strobe+2; bits 1,0,1,0,1,0,1,0 each 4 cycles; stop 4 cycles.
   - Required: tx_done pulses at cycle strobe+2+40; busy falls the following cycle.
2. Parity and two stop bits:
   - Stimulus: CONFIG_R=0xF (odd parity, 2 stop), BAUD_DIV=2, byte 0x03.
   - Required: parity bit=1; stop held 4 cycles; frame 24 cycles.
3. Overflow:
   - Stimulus: tx_en=0; 5 strobes with bytes 0x10..0x14.
   - Required: fifo_full after the 4th; overflow pulses on the 5th; 0x14 is lost.
   - Then set tx_en=1: frames carry 0x10,0x11,0x12,0x13, each separated by one idle cycle.
4. Push/pop same cycle when full:
   - Stimulus: FIFO full and IDLE; assert tx_en and new_data in the same cycle.
   - Required: byte accepted; fifo_count stays 4; no overflow.
5. BAUD_DIV=0 and mid-frame changes:
   - BAUD_DIV=0 gives 1-cycle bits (10-cycle 8N1 frame).
   - Changing BAUD_DIV/CONFIG_R during DATA leaves the frame unaltered.
6. Reset mid-frame:
   - Stimulus: assert reset during DATA bit 3.
   - Required: next edge tx=1, fifo_count=0, no tx_done.
   - With UART_TX_OVF_CNT_EN: ovf_count also returns to 0.
